lattice_sweep_core: RTL
=======================

Name: lattice_sweep_core

Overview:
- Multi-lane successor of the single-lane lattice mining core.
- Accepts a nonce-range job and sweeps it across NUM_LANES external fixed-latency double-SHA lanes.
- Tags in-flight nonces, checks returned hashes against a leading-zero difficulty, and queues winning nonces in a result FIFO with valid/ready output.
- Sits between the job dispatcher and the processor results collector.

Parameters:
INDEX, 0, processor index reported on processor_index (8 bits)
NUM_LANES, 4, hash lanes issued per cycle (1..16)
NONCE_W, 32, nonce width
HASH_LATENCY, 64, cycles from lane_valid_o/lane_nonce_o to matching lane_hash_i (>=1)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
job_valid  in  1  job offered
job_ready  out  1  core can accept a job (high only in IDLE)
job_nonce_start  in  NONCE_W  first nonce, inclusive
job_nonce_end  in  NONCE_W  last nonce, inclusive
job_difficulty  in  8  required leading zero bits of hash
job_id  in  8  tag copied into results
abort  in  1  cancel current job
lane_valid_o  out  NUM_LANES  per-lane issue strobe
lane_nonce_o  out  NUM_LANES*NONCE_W  lane l nonce at [l*NONCE_W +: NONCE_W]
lane_hash_i  in  NUM_LANES*256  lane l hash at [l*256 +: 256], valid HASH_LATENCY cycles after issue
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer pops head when res_valid&res_ready
res_nonce  out  NONCE_W  winning nonce
res_job_id  out  8  job_id of winning nonce
processor_index  out  8  constant INDEX
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
overflow  out  1  sticky: a hit was dropped

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; FIFO emptied; tag pipeline valids cleared.
  - lane_valid_o=0, res_valid=0, done=0, overflow=0, busy=0; job_ready=1 from the first cycle after reset is released.
  - Reset mid-sweep discards everything; no done pulse.
- IDLE:
  - job_ready=1.
  - On job_valid: capture start, end, difficulty, id; clear overflow; base<=start.
  - If end<start, go to DRAIN with nothing issued; otherwise go to SWEEP.
- SWEEP: each cycle issues one group.
  - lane l nonce = base+l (NONCE_W-bit, no wrap).
  - lane_valid_o[l] = (base+l <= end), compared at NONCE_W+1 bits.
  - If base+NUM_LANES-1 >= end (NONCE_W+1-bit math), this is the last group: go to DRAIN. Otherwise base += NUM_LANES.
  - end=2^NONCE_W-1 must terminate without wrap.
- DRAIN: counter runs HASH_LATENCY+1 cycles after the last issue cycle, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Tag pipeline: HASH_LATENCY-deep shift of {base, lane mask, job_id}, aligned so the tag exits together with lane_hash_i.
- Hit check: hit[l] = mask[l] & (leading zeros of hash, counted from bit 255, >= difficulty).
  - Difficulty 0 means every valid lane hits. Difficulty >255 never hits; a 256-zero hash hits for any difficulty <=255.
  - Hits are registered (1 cycle), then written to the FIFO.
  - A result is visible on res_valid 2 cycles after its hash arrives.
- FIFO write, at most one per cycle:
  - Lowest-index hitting lane is written. Any other simultaneous hits are dropped and set overflow.
  - Hit while FIFO full (no simultaneous pop) is dropped and sets overflow.
  - Simultaneous push and pop when full is allowed (no drop).
- abort:
  - In SWEEP or DRAIN: issuing stops that cycle, all tag valids are cleared (in-flight hashes ignored), state returns to IDLE, and done is not pulsed.
  - FIFO contents are kept. abort is ignored in IDLE.
- job_valid outside IDLE is ignored (job_ready=0).

Test Plan:
- NUM_LANES=4, start=0x10, end=0x1B, difficulty=255 -> 3 issue cycles, masks 1111 with bases 0x10/0x14/0x18; done pulses once, HASH_LATENCY+2 cycles after last issue; no results.
- start=0, end=5 -> groups mask 1111 (0-3) then 0011 (lanes 0,1 = 4,5); start=0xFFFFFFFE, end=0xFFFFFFFF -> single group mask 0011, no wrap, done; start=5, end=4 -> nothing issued, done pulses.
- Hash model returns 40 leading zeros for nonce 0x13, job_id=0xA5, difficulty=32 -> one result {0x13,0xA5} exactly 2 cycles after hash; repeat with difficulty=41 -> no result.
- Lanes 1 and 3 hit in the same cycle -> only lane-1 nonce queued, overflow=1. FIFO_DEPTH=2, res_ready=0, 3 hits -> 2 entries, overflow=1. Then pop with res_ready=1 -> FIFO order preserved.
- abort in cycle 2 of SWEEP with pending hits -> lane_valid_o=0 next cycle, busy=0, no done, in-flight hits not queued, earlier FIFO entries retained.
- rst=0 mid-DRAIN -> all outputs reset, FIFO empty; a new job is accepted one cycle after release; processor_index==INDEX throughout.

Source files
------------

// File: rtl/lattice_sweep_core.sv
// lattice_sweep_core: sweeps a nonce range across NUM_LANES fixed-latency
// hash lanes, checks returned hashes against a leading-zero difficulty and
// queues winning nonces in a small result FIFO.
module lattice_sweep_core #(
  parameter logic [7:0]  INDEX        = 8'd0,
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned NONCE_W      = 32,
  parameter int unsigned HASH_LATENCY = 64,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [NONCE_W-1:0]             job_nonce_start,
  input  logic [NONCE_W-1:0]             job_nonce_end,
  input  logic [7:0]                     job_difficulty,
  input  logic [7:0]                     job_id,
  input  logic                           abort,
  output logic [NUM_LANES-1:0]           lane_valid_o,
  output logic [NUM_LANES*NONCE_W-1:0]   lane_nonce_o,
  input  logic [NUM_LANES*256-1:0]       lane_hash_i,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [NONCE_W-1:0]             res_nonce,
  output logic [7:0]                     res_job_id,
  output logic [7:0]                     processor_index,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(HASH_LATENCY + 1);
  localparam logic [NONCE_W:0] LANES_M1 = (NONCE_W+1)'(NUM_LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic [NONCE_W-1:0]   base;
  logic [NONCE_W-1:0]   nonce_end;
  logic [7:0]           difficulty;
  logic [7:0]           cur_id;
  logic [CW-1:0]        drain_cnt;
  logic                 kill;
  logic                 last_group;

  logic [NUM_LANES-1:0] tag_mask [HASH_LATENCY];
  logic [NONCE_W-1:0]   tag_base [HASH_LATENCY];
  logic [7:0]           tag_id   [HASH_LATENCY];

  logic [NUM_LANES-1:0] hit_vec;
  logic                 hit_found;
  logic                 hit_many;
  logic [NONCE_W-1:0]   hit_first;
  logic                 hit_vld_q;
  logic                 hit_multi_q;
  logic [NONCE_W-1:0]   hit_nonce_q;
  logic [7:0]           hit_id_q;

  logic [NONCE_W-1:0]   fifo_nonce [FIFO_DEPTH];
  logic [7:0]           fifo_id    [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 push_req;
  logic                 push;

  function automatic logic [8:0] lead_zeros(input logic [255:0] h);
    logic [8:0] n;
    logic       stop;
    n    = '0;
    stop = 1'b0;
    for (int unsigned b = 0; b < 256; b++) begin
      if (!stop) begin
        if (h[255-b]) stop = 1'b1;
        else          n = n + 9'd1;
      end
    end
    return n;
  endfunction

  assign processor_index = INDEX;
  assign job_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign kill            = abort && ((state == S_SWEEP) || (state == S_DRAIN));
  assign last_group      = ({1'b0, base} + LANES_M1) >= {1'b0, nonce_end};

  // Lane issue: range compare at NONCE_W+1 bits so the top of the range cannot wrap.
  always_comb begin
    lane_valid_o = '0;
    lane_nonce_o = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      lane_nonce_o[l*NONCE_W +: NONCE_W] = base + NONCE_W'(l);
      lane_valid_o[l] = (state == S_SWEEP) && !abort &&
                        (({1'b0, base} + (NONCE_W+1)'(l)) <= {1'b0, nonce_end});
    end
  end

  // Job sequencing: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      base       <= '0;
      nonce_end  <= '0;
      difficulty <= '0;
      cur_id     <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (job_valid) begin
          base       <= job_nonce_start;
          nonce_end  <= job_nonce_end;
          difficulty <= job_difficulty;
          cur_id     <= job_id;
          drain_cnt  <= '0;
          state      <= (job_nonce_end < job_nonce_start) ? S_DRAIN : S_SWEEP;
        end
        S_SWEEP: begin
          if (abort)           state <= S_IDLE;
          else if (last_group) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else             base  <= base + NONCE_W'(NUM_LANES);
        end
        S_DRAIN: begin
          if (abort)                                  state <= S_IDLE;
          else if (drain_cnt == CW'(HASH_LATENCY))    state <= S_DONE;
          else                                        drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline: stage HASH_LATENCY-1 lines up with the hashes on lane_hash_i.
  always_ff @(posedge clk) begin
    if (!rst || kill) begin
      for (int unsigned i = 0; i < HASH_LATENCY; i++) tag_mask[i] <= '0;
    end else begin
      tag_mask[0] <= lane_valid_o;
      tag_base[0] <= base;
      tag_id[0]   <= cur_id;
      for (int unsigned i = 1; i < HASH_LATENCY; i++) begin
        tag_mask[i] <= tag_mask[i-1];
        tag_base[i] <= tag_base[i-1];
        tag_id[i]   <= tag_id[i-1];
      end
    end
  end

  // Per-lane difficulty check against the returned hash.
  always_comb begin
    hit_vec = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++)
      hit_vec[l] = tag_mask[HASH_LATENCY-1][l] &&
                   (lead_zeros(lane_hash_i[l*256 +: 256]) >= {1'b0, difficulty});
  end

  // Lowest hitting lane wins; any further hit in the same cycle is a drop.
  always_comb begin
    hit_found = 1'b0;
    hit_many  = 1'b0;
    hit_first = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (hit_vec[l]) begin
        if (hit_found) hit_many = 1'b1;
        else begin
          hit_found = 1'b1;
          hit_first = tag_base[HASH_LATENCY-1] + NONCE_W'(l);
        end
      end
    end
  end

  // Hit register between the compare and the FIFO write.
  always_ff @(posedge clk) begin
    if (!rst || kill) begin
      hit_vld_q   <= 1'b0;
      hit_multi_q <= 1'b0;
      hit_nonce_q <= '0;
      hit_id_q    <= '0;
    end else begin
      hit_vld_q   <= hit_found;
      hit_multi_q <= hit_many;
      hit_nonce_q <= hit_first;
      hit_id_q    <= tag_id[HASH_LATENCY-1];
    end
  end

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign res_valid = (wr_ptr != rd_ptr);
  assign pop       = res_valid && res_ready;
  assign push_req  = hit_vld_q && !kill;
  assign push      = push_req && (!full || pop);
  assign res_nonce  = fifo_nonce[rd_ptr[AW-1:0]];
  assign res_job_id = fifo_id[rd_ptr[AW-1:0]];

  // Result FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Result FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_nonce[wr_ptr[AW-1:0]] <= hit_nonce_q;
      fifo_id[wr_ptr[AW-1:0]]    <= hit_id_q;
    end
  end

  // Sticky drop flag, cleared when a new job is taken.
  always_ff @(posedge clk) begin
    if (!rst)                                      overflow <= 1'b0;
    else if (state == S_IDLE && job_valid)         overflow <= 1'b0;
    else if (push_req && (hit_multi_q || (full && !pop))) overflow <= 1'b1;
  end

endmodule
